// File: rtl/cdp_intp_arb_pkg.sv
// Shared widths and operand layout for the CDP interpolation arbiter.
package cdp_intp_arb_pkg;

    localparam int IN0_W   = 39;
    localparam int IN1_W   = 38;
    localparam int X0_W    = 17;
    localparam int SCALE_W = 17;
    localparam int SHIFT_W = 6;
    localparam int RES_W   = 17;
    localparam int OP_W    = IN0_W + IN1_W + X0_W + SCALE_W + SHIFT_W;

    typedef struct packed {
        logic [IN0_W-1:0]   in0;
        logic [IN1_W-1:0]   in1;
        logic [X0_W-1:0]    x0;
        logic [SCALE_W-1:0] scale;
        logic [SHIFT_W-1:0] shift;
    } cdp_intp_op_t;

    // Lane-id width; a single-lane build still needs one bit to hold an id.
    function automatic int lane_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/cdp_intp_tag_fifo.sv
// In-order FIFO of lane ids for operations in flight in the interpolation unit.
module cdp_intp_tag_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Full comes straight off the count register, so a same-cycle pop never frees a slot early.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/cdp_intp_arbiter.sv
// Round-robin issue of lane operands into the shared CDP interpolation unit,
// with in-order steering of results back to the issuing lane.
module cdp_intp_arbiter
    import cdp_intp_arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int TAG_DEPTH = 4,
    localparam int LANE_W    = lane_w(NREQ),
    localparam int CNT_W     = $clog2(TAG_DEPTH + 1)
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [NREQ-1:0]        req_vld,
    output logic [NREQ-1:0]        req_rdy,
    input  logic [NREQ*OP_W-1:0]   req_pd,
    output logic                   intp_in_vld,
    input  logic                   intp_in_rdy,
    output logic [IN0_W-1:0]       intp_in0_pd,
    output logic [IN1_W-1:0]       intp_in1_pd,
    output logic [X0_W-1:0]        intp_in_pd,
    output logic [SCALE_W-1:0]     intp_in_scale,
    output logic [SHIFT_W-1:0]     intp_in_shift,
    input  logic                   intp_out_vld,
    output logic                   intp_out_rdy,
    input  logic [RES_W-1:0]       intp_out_pd,
    output logic [NREQ-1:0]        rsp_vld,
    input  logic [NREQ-1:0]        rsp_rdy,
    output logic [RES_W-1:0]       rsp_pd,
    output logic [CNT_W-1:0]       inflight_cnt,
    output logic                   tag_err
);

    cdp_intp_op_t      lane_op [NREQ];
    cdp_intp_op_t      sel_op;
    logic [LANE_W-1:0] rr_ptr;
    logic [LANE_W-1:0] gnt_id;
    logic [LANE_W-1:0] sel_id;
    logic [LANE_W-1:0] head_id;
    logic [LANE_W:0]   cand;
    logic              gnt_any;
    logic              can_issue;
    logic              issue;
    logic              pop;
    logic              tag_full;
    logic              tag_empty;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign lane_op[i] = req_pd[i*OP_W +: OP_W];
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = rr_ptr;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (LANE_W+1)'(i);
            if (cand >= (LANE_W+1)'(NREQ))
                cand = cand - (LANE_W+1)'(NREQ);
            if (!gnt_any && req_vld[cand[LANE_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = cand[LANE_W-1:0];
            end
        end
    end

    // Valid is only raised together with a tag push; the unit latches its stage-0 valid on vld alone.
    assign can_issue   = intp_in_rdy & ~tag_full;
    assign issue       = can_issue & gnt_any;
    assign intp_in_vld = issue;

    always_comb begin
        req_rdy = '0;
        if (issue) req_rdy[gnt_id] = 1'b1;
    end

    assign sel_id        = issue ? gnt_id : rr_ptr;
    assign sel_op        = lane_op[sel_id];
    assign intp_in0_pd   = sel_op.in0;
    assign intp_in1_pd   = sel_op.in1;
    assign intp_in_pd    = sel_op.x0;
    assign intp_in_scale = sel_op.scale;
    assign intp_in_shift = sel_op.shift;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)
            rr_ptr <= '0;
        else if (issue)
            rr_ptr <= (gnt_id == LANE_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    // With no tag outstanding any result is an orphan: drain it and flag the error.
    always_comb begin
        rsp_vld      = '0;
        intp_out_rdy = 1'b1;
        if (!tag_empty) begin
            rsp_vld[head_id] = intp_out_vld;
            intp_out_rdy     = rsp_rdy[head_id];
        end
    end

    assign pop    = intp_out_vld & intp_out_rdy & ~tag_empty;
    assign rsp_pd = intp_out_pd;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)
            tag_err <= 1'b0;
        else if (intp_out_vld && tag_empty)
            tag_err <= 1'b1;
    end

    cdp_intp_tag_fifo #(
        .WIDTH (LANE_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .push            (issue),
        .push_data       (gnt_id),
        .pop             (pop),
        .full            (tag_full),
        .empty           (tag_empty),
        .head            (head_id),
        .count           (inflight_cnt)
    );

endmodule

// File: doc/cdp_intp_arbiter.md
# cdp_intp_arbiter

Round-robin scheduler that shares one CDP interpolation unit (3-stage valid/ready pipeline, 17-bit result) among NREQ requesting lanes. It issues one lane's operand set per cycle into the unit and records the lane id in an in-order tag FIFO. Each returning result is steered back to the lane that issued it. It sits between the CDP LUT-lookup lanes and the shared interpolation datapath.

## Interface
- NREQ, 4: number of requesting lanes (2..8).
- TAG_DEPTH, 4: tag FIFO depth, equal to the maximum number of operations in flight (≥4 covers full unit throughput).
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- req_vld  in  NREQ  per-lane operand valid.
- req_rdy  out  NREQ  per-lane accept; at most one bit set.
- req_pd  in  NREQ*117  per lane, packed {in0[38:0], in1[37:0], x0[16:0], scale[16:0], shift[5:0]}.
- intp_in_vld  out  1  issue valid to the unit.
- intp_in_rdy  in  1  unit accept.
- intp_in0_pd / intp_in1_pd / intp_in_pd / intp_in_scale / intp_in_shift  out  39/38/17/17/6  granted lane's fields.
- intp_out_vld  in  1  unit result valid.
- intp_out_rdy  out  1  result accept to the unit.
- intp_out_pd  in  17  unit result.
- rsp_vld  out  NREQ  per-lane result valid; at most one bit set.
- rsp_rdy  in  NREQ  per-lane result accept.
- rsp_pd  out  17  result, broadcast to all lanes (equals intp_out_pd).
- inflight_cnt  out  $clog2(TAG_DEPTH+1)  operations issued and not yet returned.
- tag_err  out  1  sticky: result arrived while the tag FIFO was empty.

## Operation
- can_issue = intp_in_rdy & ~tag_full.
- Grant:
  - Combinational.
  - g = the first lane with req_vld set, searching from rr_ptr upward modulo NREQ.
  - If can_issue and any req_vld: intp_in_vld=1, req_rdy[g]=1, operand outputs = lane g fields.
  - Otherwise intp_in_vld=0, req_rdy=0, and operand outputs hold lane rr_ptr fields (value is don't-care).
- intp_in_vld must never be asserted without an issue. The unit sets its stage-0 valid on vld alone, so a vld without a matching push would orphan a result.
- Issue (intp_in_vld & intp_in_rdy): push g into the tag FIFO and set rr_ptr <= (g+1) mod NREQ. rr_ptr is unchanged when nothing is issued.
- Return:
  - When the FIFO is non-empty, h = FIFO head.
  - rsp_vld[h] = intp_out_vld.
  - intp_out_rdy = rsp_rdy[h].
  - Pop on intp_out_vld & intp_out_rdy.
  - When the FIFO is empty: rsp_vld=0 and intp_out_rdy=1 (any result is drained). If intp_out_vld=1 in this state, set tag_err.
- inflight_cnt: +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- Full: issue is blocked when the FIFO holds TAG_DEPTH entries, even if a pop happens the same cycle. This is a registered decision with no pop→push combinational path.
- Results return in issue order. A lane is never reordered against itself or against other lanes.

## Timing
- Reset values: rr_ptr=0, FIFO empty, inflight_cnt=0, tag_err=0. All outputs derive from these, so intp_in_vld=0, req_rdy=0, rsp_vld=0, intp_out_rdy=1.
- Grant-to-issue latency is 0 cycles. Issue-to-rsp_vld is 3 cycles minimum (unit latency), more under back-pressure.
- Sustained throughput is 1 op/cycle when the lanes and rsp_rdy are not stalled.
- Back-pressure: a low rsp_rdy[h] holds intp_out_rdy low. The unit then deasserts intp_in_rdy after its pipeline fills, and issue stalls naturally.
- Reset asserted mid-operation clears all state immediately. The unit is reset by the same signal, so no orphan results remain.

## Structure
- Package cdp_intp_arb_pkg holds:
  - field widths (39/38/17/17/6);
  - the 117-bit packed operand struct;
  - the lane-id width LANE_W = $clog2(NREQ).
- Sub-module cdp_intp_tag_fifo:
  - synchronous FIFO, LANE_W wide, TAG_DEPTH deep;
  - wrapping rd/wr pointers plus a count;
  - outputs full, empty, head, count.
- The top level contains the round-robin search, operand mux, return steering and error flag.

## Test plan
- Single lane 0, one op (in0=100, in1=300, scale=0x8000, shift=16, x0=100). Expect rsp_vld[0] exactly 3 cycles after issue, rsp_pd=200, inflight_cnt back to 0.
- All 4 lanes requesting continuously. Expect grant order 0,1,2,3,0,…, one issue per cycle, and each rsp_vld bit in the same order with its own lane's result.
- Lanes 1 and 3 only, with rr_ptr=2 at start. Expect first grant to lane 3, then 1, then 3.
- rsp_rdy[h]=0 for 10 cycles while all lanes request. Expect at most TAG_DEPTH ops in flight, intp_in_vld=0 while full, then ordered drain and resume with no lost or duplicated result.
- Force intp_out_vld=1 with the FIFO empty. Expect tag_err to rise the next cycle and stay set until reset, with all rsp_vld=0.
- Assert reset with 3 ops in flight. Expect inflight_cnt=0, rr_ptr=0, rsp_vld=0 immediately, and a normal first op after release.
